// File: rtl/oserdes_pattern_pkg.sv
// Shared encodings for the OSERDES pattern sequencer: mode inputs, FSM states
// and a width helper for counters sized from parameters.
package oserdes_pattern_pkg;

  localparam logic [1:0] MODE_IDLE    = 2'b00;
  localparam logic [1:0] MODE_LOOP    = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_LOOP  = 2'd2;
  localparam logic [1:0] ST_BURST = 2'd3;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oserdes_pattern_ram.sv
// Simple dual-port pattern store: synchronous write, synchronous read-before-write.
// The read register doubles as the word_out register, loading RST_WORD when not reading.
module oserdes_pattern_ram #(
  parameter int unsigned   DW       = 4,
  parameter int unsigned   AW       = 4,
  parameter logic [DW-1:0] RST_WORD = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge clock) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Non-blocking read of r_mem gives old data on a same-address collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_rd_data <= RST_WORD;
    else       r_rd_data <= rd_en ? r_mem[rd_addr] : RST_WORD;
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/oserdes_pattern_sequencer.sv
// Word-clock pattern engine feeding OSERDES D inputs: serializer reset hold, idle,
// continuous loop and triggered one-shot playback. OSERDES_PATTERN_TRIG_COUNT_EN adds trig_count.
module oserdes_pattern_sequencer
  import oserdes_pattern_pkg::*;
#(
  parameter int unsigned      WIDTH             = 4,
  parameter int unsigned      CHANNELS          = 1,
  parameter int unsigned      DEPTH             = 16,
  parameter int unsigned      RESET_HOLD_CYCLES = 1024,
  parameter logic [WIDTH-1:0] IDLE_WORD         = '0,
  localparam int unsigned     AW                = $clog2(DEPTH),
  localparam int unsigned     DW                = WIDTH * CHANNELS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] loop_len,
  input  logic          trigger,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
`ifdef OSERDES_PATTERN_TRIG_COUNT_EN
  output logic [31:0]   trig_count,
`endif
  output logic [DW-1:0] word_out,
  output logic          serdes_reset,
  output logic          busy,
  output logic          done
);

  localparam int unsigned   HW        = clog2_min1(RESET_HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [DW-1:0] IDLE_ALL  = {CHANNELS{IDLE_WORD}};

  logic [1:0]    r_state;
  logic [HW-1:0] r_hold_cnt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_len;
  logic          r_serdes_reset;
  logic          r_busy;
  logic          r_done;

  logic [1:0]    w_state_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [AW-1:0] w_ptr_nxt;
  logic [AW-1:0] w_len_nxt;
  logic [AW-1:0] w_ptr_inc;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic          w_done_nxt;

  assign w_ptr_inc = r_ptr + AW'(1);

  // r_ptr tracks the address currently on word_out; w_rd_addr is the one loaded next edge.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_ptr_nxt   = r_ptr;
    w_len_nxt   = r_len;
    w_rd_en     = 1'b0;
    w_rd_addr   = '0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_HOLD: begin
        w_hold_nxt = r_hold_cnt + HW'(1);
        if (r_hold_cnt == HOLD_LAST) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (mode == MODE_LOOP || (mode == MODE_ONESHOT && trigger)) begin
          w_state_nxt = (mode == MODE_LOOP) ? ST_LOOP : ST_BURST;
          w_len_nxt   = loop_len;
          w_ptr_nxt   = '0;
          w_rd_en     = 1'b1;
          w_done_nxt  = (mode == MODE_ONESHOT) && (loop_len == '0);
        end
      end
      ST_LOOP: begin
        if (r_ptr != r_len) begin
          w_ptr_nxt = w_ptr_inc;
          w_rd_en   = 1'b1;
          w_rd_addr = w_ptr_inc;
        end else if (mode == MODE_LOOP) begin
          w_ptr_nxt = '0;
          w_rd_en   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (r_ptr != r_len) begin
          w_ptr_nxt  = w_ptr_inc;
          w_rd_en    = 1'b1;
          w_rd_addr  = w_ptr_inc;
          w_done_nxt = (w_ptr_inc == r_len);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_HOLD;
      r_hold_cnt     <= '0;
      r_ptr          <= '0;
      r_len          <= '0;
      r_serdes_reset <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_hold_cnt     <= w_hold_nxt;
      r_ptr          <= w_ptr_nxt;
      r_len          <= w_len_nxt;
      r_serdes_reset <= (w_state_nxt == ST_HOLD);
      r_busy         <= (w_state_nxt == ST_LOOP) || (w_state_nxt == ST_BURST);
      r_done         <= w_done_nxt;
    end
  end

`ifdef OSERDES_PATTERN_TRIG_COUNT_EN
  logic [31:0] r_trig_count;
  logic        w_trig_accept;

  assign w_trig_accept = (r_state == ST_IDLE) && (w_state_nxt == ST_BURST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              r_trig_count <= '0;
    else if (w_trig_accept) r_trig_count <= r_trig_count + 32'd1;
  end

  assign trig_count = r_trig_count;
`endif

  oserdes_pattern_ram #(
    .DW       (DW),
    .AW       (AW),
    .RST_WORD (IDLE_ALL)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (w_rd_en),
    .rd_addr (w_rd_addr),
    .rd_data (word_out)
  );

  assign serdes_reset = r_serdes_reset;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_oserdes_pattern_sequencer.sv
// Directed bench for oserdes_pattern_sequencer: expected output words are queued as
// stimulus is applied and compared one per clock; a second 2x8-bit instance checks channel packing.
module tb_oserdes_pattern_sequencer;

  localparam int unsigned HOLD = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [3:0]  loop_len;
  logic        trigger;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [3:0]  word_out;
  logic        serdes_reset;
  logic        busy;
  logic        done;

  logic [1:0]  c2_mode;
  logic [1:0]  c2_loop_len;
  logic        c2_trigger;
  logic        c2_wr_en;
  logic [1:0]  c2_wr_addr;
  logic [15:0] c2_wr_data;
  logic [15:0] c2_word_out;
  logic        c2_serdes_reset;
  logic        c2_busy;
  logic        c2_done;

`ifdef OSERDES_PATTERN_TRIG_COUNT_EN
  logic [31:0] trig_count;
  logic [31:0] c2_trig_count;
`endif

  always #5 clock = ~clock;

  oserdes_pattern_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode),
    .loop_len     (loop_len),
    .trigger      (trigger),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
`ifdef OSERDES_PATTERN_TRIG_COUNT_EN
    .trig_count   (trig_count),
`endif
    .word_out     (word_out),
    .serdes_reset (serdes_reset),
    .busy         (busy),
    .done         (done)
  );

  oserdes_pattern_sequencer #(
    .WIDTH             (8),
    .CHANNELS          (2),
    .DEPTH             (4),
    .RESET_HOLD_CYCLES (3),
    .IDLE_WORD         (8'h3C)
  ) dut2 (
    .clock        (clock),
    .reset        (reset),
    .mode         (c2_mode),
    .loop_len     (c2_loop_len),
    .trigger      (c2_trigger),
    .wr_en        (c2_wr_en),
    .wr_addr      (c2_wr_addr),
    .wr_data      (c2_wr_data),
`ifdef OSERDES_PATTERN_TRIG_COUNT_EN
    .trig_count   (c2_trig_count),
`endif
    .word_out     (c2_word_out),
    .serdes_reset (c2_serdes_reset),
    .busy         (c2_busy),
    .done         (c2_done)
  );

  typedef struct packed {
    logic [3:0] w;
    logic       d;
    logic       b;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mdl[16];
  int         n_vec = 0;
  int         n_err = 0;
  int         exp_trig = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] w, input logic d, input logic b);
    exp_t e;
    e.w = w;
    e.d = d;
    e.b = b;
    sb.push_back(e);
  endtask

  // Each clock pops one expectation: {word_out, done, busy, serdes_reset}.
  task automatic run(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL %s: observed=empty expected queue entry", tag);
      end else begin
        e = sb.pop_front();
        chk(tag, 32'({word_out, done, busy, serdes_reset}), 32'({e.w, e.d, e.b, 1'b0}));
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    mdl[a]  = d;
  endtask

  // Called just after a clock edge with reset high; trigger is held to prove HOLD ignores it.
  task automatic measure_hold();
    int cnt = 0;
    int bad = 0;
    reset   = 1'b0;
    mode    = 2'b10;
    trigger = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock);
      #1;
      cnt++;
      if (word_out !== 4'h0 || busy !== 1'b0 || done !== 1'b0) bad++;
      if (serdes_reset !== 1'b1) break;
    end
    mode    = 2'b00;
    trigger = 1'b0;
    chk("hold_len", 32'(cnt), 32'(HOLD));
    chk("hold_quiet", 32'(bad), 32'd0);
    push(4'h0, 1'b0, 1'b0);
    push(4'h0, 1'b0, 1'b0);
    run(2, "hold_exit");
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat [4];
    logic [3:0] nv;
    pat = '{4'hB, 4'h1, 4'hF, 4'h6};

    reset = 1'b1; mode = 2'b00; loop_len = 4'd0; trigger = 1'b0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 4'd0;
    c2_mode = 2'b00; c2_loop_len = 2'd0; c2_trigger = 1'b0;
    c2_wr_en = 1'b0; c2_wr_addr = 2'd0; c2_wr_data = 16'd0;

    #12;
    chk("reset_state", 32'({word_out, serdes_reset, busy, done}), 32'({4'h0, 1'b1, 1'b0, 1'b0}));
    chk("c2_reset_idle", 32'(c2_word_out), 32'h3C3C);
`ifdef OSERDES_PATTERN_TRIG_COUNT_EN
    chk("reset_trig_count", trig_count, 32'd0);
`endif
    @(posedge clock);
    #1;
    measure_hold();
`ifdef OSERDES_PATTERN_TRIG_COUNT_EN
    chk("hold_trig_count", trig_count, 32'd0);
`endif

    for (int i = 0; i < 4; i++) begin
      wr(4'(i), pat[i]);
      push(4'h0, 1'b0, 1'b0);
      run(1, "load");
    end
    wr_en = 1'b0;

    // One-shot of four words with a single-cycle trigger.
    loop_len = 4'd3; mode = 2'b10; trigger = 1'b1;
    for (int i = 0; i < 4; i++) push(mdl[i], i == 3, 1'b1);
    push(4'h0, 1'b0, 1'b0);
    run(1, "burst");
    trigger = 1'b0;
    run(4, "burst");
    exp_trig++;

    // Loop of two words; triggers during LOOP are ignored; stop requested mid-pattern.
    loop_len = 4'd1; mode = 2'b01;
    for (int k = 0; k < 5; k++) push(mdl[k % 2], 1'b0, 1'b1);
    run(1, "loop");
    trigger = 1'b1;
    run(4, "loop");
    mode = 2'b00; trigger = 1'b0;
    push(mdl[1], 1'b0, 1'b1);
    push(4'h0, 1'b0, 1'b0);
    run(2, "loop_stop");

    // Held trigger re-fires only after IDLE; mode change mid-burst is ignored.
    loop_len = 4'd3; mode = 2'b10; trigger = 1'b1;
    for (int i = 0; i < 4; i++) push(mdl[i], i == 3, 1'b1);
    push(4'h0, 1'b0, 1'b0);
    push(mdl[0], 1'b0, 1'b1);
    run(6, "retrig");
    exp_trig += 2;
    trigger = 1'b0; mode = 2'b01; loop_len = 4'd0;
    for (int i = 1; i < 4; i++) push(mdl[i], i == 3, 1'b1);
    run(3, "burst_mode_ign");
    mode = 2'b00;
    push(4'h0, 1'b0, 1'b0);
    run(1, "burst_end");
`ifdef OSERDES_PATTERN_TRIG_COUNT_EN
    chk("trig_count_bursts", trig_count, 32'(exp_trig));
`endif

    // Two-channel 8-bit instance: channel 1 lands in word_out[15:8].
    c2_wr_en = 1'b1; c2_wr_addr = 2'd0; c2_wr_data = 16'h1234;
    push(4'h0, 1'b0, 1'b0);
    run(1, "idle");
    c2_wr_addr = 2'd1; c2_wr_data = 16'hA55A;
    push(4'h0, 1'b0, 1'b0);
    run(1, "idle");
    c2_wr_en = 1'b0;
    chk("c2_idle", 32'({c2_word_out, c2_serdes_reset, c2_busy}), 32'({16'h3C3C, 1'b0, 1'b0}));
    c2_loop_len = 2'd1; c2_mode = 2'b10; c2_trigger = 1'b1;
    push(4'h0, 1'b0, 1'b0);
    run(1, "idle");
    chk("c2_word0", 32'({c2_word_out, c2_done, c2_busy}), 32'({16'h1234, 1'b0, 1'b1}));
    c2_trigger = 1'b0; c2_mode = 2'b00;
    push(4'h0, 1'b0, 1'b0);
    run(1, "idle");
    chk("c2_word1", 32'({c2_word_out, c2_done, c2_busy}), 32'({16'hA55A, 1'b1, 1'b1}));
    chk("c2_ch1", 32'(c2_word_out[15:8]), 32'h00A5);
    push(4'h0, 1'b0, 1'b0);
    run(1, "idle");
    chk("c2_end", 32'({c2_word_out, c2_done, c2_busy}), 32'({16'h3C3C, 1'b0, 1'b0}));

    // Asynchronous reset in the middle of a burst.
    loop_len = 4'd3; mode = 2'b10; trigger = 1'b1;
    push(mdl[0], 1'b0, 1'b1);
    push(mdl[1], 1'b0, 1'b1);
    run(1, "pre_reset");
    trigger = 1'b0;
    run(1, "pre_reset");
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", 32'({word_out, serdes_reset, busy, done}), 32'({4'h0, 1'b1, 1'b0, 1'b0}));
`ifdef OSERDES_PATTERN_TRIG_COUNT_EN
    chk("async_reset_trig", trig_count, 32'd0);
`endif
    exp_trig = 0;
    @(posedge clock);
    #1;
    measure_hold();

    // loop_len=0 one-shot: single word with done.
    loop_len = 4'd0; mode = 2'b10; trigger = 1'b1;
    push(mdl[0], 1'b1, 1'b1);
    push(4'h0, 1'b0, 1'b0);
    run(1, "len0");
    trigger = 1'b0; mode = 2'b00;
    run(1, "len0");
    exp_trig++;

    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 4'(i * 7 + 3));
      push(4'h0, 1'b0, 1'b0);
      run(1, "load16");
    end
    wr_en = 1'b0;

    // Full-depth loop; a write to the address being read returns old data this period.
    loop_len = 4'd15; mode = 2'b01;
    for (int i = 0; i < 5; i++) push(mdl[i], 1'b0, 1'b1);
    run(5, "loop16");
    push(mdl[5], 1'b0, 1'b1);
    nv = ~mdl[5];
    wr(4'd5, nv);
    run(1, "rbw");
    wr_en = 1'b0;
    for (int i = 6; i < 16; i++) push(mdl[i], 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) push(mdl[i], 1'b0, 1'b1);
    run(26, "loop16");
    mode = 2'b00;
    push(4'h0, 1'b0, 1'b0);
    run(1, "loop16_stop");
`ifdef OSERDES_PATTERN_TRIG_COUNT_EN
    chk("trig_count_final", trig_count, 32'(exp_trig));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/oserdes_pattern_sequencer.md
Name: oserdes_pattern_sequencer

Overview:
- Word-clock-domain pattern engine that feeds the parallel D inputs of one or more OSERDES serializers.
- Generalises the hard-wired single-channel 4-bit trigger pattern into:
  - a programmable, DEPTH-word pattern memory per channel;
  - selectable idle, continuous-loop or triggered one-shot modes;
  - a built-in serializer reset-hold sequencer.
- Sits between trigger/control logic and the vendor OSERDES instances. Primitives stay outside this block.

Parameters:
- WIDTH, 4, serializer data width (bits per word per channel).
- CHANNELS, 1, number of parallel serializer channels.
- DEPTH, 16, pattern words per channel; power of 2, >=2; AW = log2(DEPTH).
- RESET_HOLD_CYCLES, 1024, clocks serdes_reset stays high after reset release; >=1.
- IDLE_WORD, 0, per-channel word driven when not playing; replicated across channels.

Ports:
- clock  in  1  divided word clock (BUFG-driven CLKDIV domain).
- reset  in  1  asynchronous, active-high.
- mode  in  2  00 idle, 01 loop, 10 one-shot, 11 reserved (treated as idle).
- loop_len  in  AW  index of last pattern word; pattern length = loop_len+1.
- trigger  in  1  one-shot start request, level-sampled each clock.
- wr_en  in  1  pattern memory write enable.
- wr_addr  in  AW  pattern memory write address.
- wr_data  in  CHANNELS*WIDTH  word for all channels; channel c at [c*WIDTH +: WIDTH].
- word_out  out  CHANNELS*WIDTH  registered word to OSERDES D1..Dn; bit 0 maps to D1.
- serdes_reset  out  1  drive to OSERDES RST.
- busy  out  1  high in LOOP or BURST.
- done  out  1  one-cycle pulse marking the last word of a one-shot.
- trig_count  out  32  accepted-trigger count (only with optional feature).

Behaviour:
- Reset (async) values:
  - state=HOLD; hold counter=0; word_out=IDLE_WORD; serdes_reset=1; busy=0; done=0; trig_count=0; read pointer=0.
  - Pattern memory is not cleared.
  - Reset asserted mid-operation forces all of the above immediately, without waiting for a clock edge.
- States:
  - HOLD:
    - hold counter increments each clock.
    - At count RESET_HOLD_CYCLES-1, go to IDLE. serdes_reset falls on the same edge, so it is high for exactly RESET_HOLD_CYCLES clocks.
    - mode and trigger are ignored.
  - IDLE:
    - word_out=IDLE_WORD.
    - mode=01: latch loop_len, go to LOOP; word_out=pattern[0] on the next edge.
    - mode=10 and trigger=1: latch loop_len, go to BURST; word_out=pattern[0] on the next edge.
    - Latency from trigger sample to first word on word_out: 1 clock.
  - LOOP:
    - Pointer advances 1 per clock and wraps from latched loop_len to 0.
    - mode is checked only when word pattern[loop_len] is output. If mode != 01 at that point, go to IDLE and output IDLE_WORD on the next edge. The pattern always completes.
  - BURST:
    - Outputs pattern[0..loop_len] on consecutive edges.
    - done=1 for the single cycle word_out=pattern[loop_len].
    - The next edge outputs IDLE_WORD and returns to IDLE.
    - mode changes and triggers during BURST are ignored, not queued.
    - A trigger held high re-fires only after IDLE has been re-entered.
- loop_len edge cases:
  - loop_len=0: single word. LOOP repeats it; BURST emits one word, with done in the same cycle.
  - loop_len=DEPTH-1: all DEPTH words.
- Memory:
  - Synchronous write; synchronous read feeding the word_out register. Total trigger-to-word_out latency remains 1.
  - Writes are allowed during playback.
  - A write and read to the same address on the same edge returns the old data (read-before-write).
- busy=1 exactly in LOOP/BURST. word_out only changes on clock edges.

Optional Feature:
- Macro: OSERDES_PATTERN_TRIG_COUNT_EN.
- Defined:
  - trig_count increments (wraps at 2^32) on each edge where IDLE->BURST is taken.
  - Ignored triggers (HOLD, BURST, LOOP, mode!=10) do not count.
- Undefined: trig_count port is absent and there is no counter logic.

Decomposition:
- Package oserdes_pattern_pkg holds:
  - mode encodings MODE_IDLE/MODE_LOOP/MODE_ONESHOT;
  - state enum HOLD/IDLE/LOOP/BURST.
- One sub-module, oserdes_pattern_ram: DEPTH x (CHANNELS*WIDTH) simple dual-port, sync write, sync read-before-write.
- Sequencer FSM, hold counter and optional trigger counter live in the top module.

Test Plan:
1. Reset hold: pulse reset, release -> serdes_reset=1 for exactly 1024 clocks then 0; word_out=0000 throughout; trigger during HOLD gives no playback.
2. One-shot: load 1011,0001,1111,0110 at addresses 0-3; loop_len=3; mode=10; 1-clock trigger -> word_out 1011,0001,1111,0110 on the next 4 edges; done=1 only with 0110; then 0000; busy high for 4 cycles.
3. Loop: loop_len=1, mode=01 -> 1011,0001 repeating. Drop mode to 00 while 1011 is output -> 0001 still emitted, then 0000.
4. Collisions: second trigger mid-burst and a trigger held high -> no restart until IDLE is re-entered. With the macro, trig_count equals accepted bursts only (e.g. 2 after two bursts).
5. Async reset mid-burst -> word_out=0000, serdes_reset=1, busy=0 before the next clock edge; the HOLD sequence restarts.
6. Bounds: loop_len=0 in BURST -> one word with done. loop_len=15 in LOOP -> 16-word period. CHANNELS=2, WIDTH=8 build -> channel 1 data appears on word_out[15:8].
